// File: rtl/wshbn_slave_bridge_pkg.sv
// Shared types and constants for the CPU-bus to Wishbone slave bridge.
package wshbn_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wshbn_state_t;

  // Only whole-word accesses are generated on the peripheral bus.
  localparam logic [3:0] WB_SEL_WORD = 4'hF;

  // The CPU side carries word addresses; Wishbone carries byte addresses.
  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/wshbn_slave_bridge_if.sv
// Bundles the CPU-side request bus and the Wishbone master port of the bridge.
// The slave modport is the bridge's view (responder on the CPU bus, initiator
// on Wishbone); the master modport is the view of the surrounding system.
interface wshbn_slave_bridge_if;

  logic        wshbn_rd;
  logic        wshbn_wr;
  logic [29:0] wshbn_addr_i;
  logic [31:0] wshbn_data_i;
  logic [31:0] wshbn_data_o;
  logic        wshbn_busy;
  logic        wshbn_data_av;
  logic        bus_err_o;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport slave (
    input  wshbn_rd, wshbn_wr, wshbn_addr_i, wshbn_data_i,
    output wshbn_data_o, wshbn_busy, wshbn_data_av, bus_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport master (
    output wshbn_rd, wshbn_wr, wshbn_addr_i, wshbn_data_i,
    input  wshbn_data_o, wshbn_busy, wshbn_data_av, bus_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/wshbn_slave_bridge_timeout_cnt.sv
// Counts cycles spent waiting on the peripheral and flags the abort point.
// The count saturates at the limit instead of wrapping; the bridge leaves
// the bus cycle when expired is seen, so the counter never needs to run past it.
module wshbn_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // A zero limit disables the timeout; keep a legal 1-bit counter in that case.
  localparam int CW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int LIMIT = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [CW-1:0] LIMIT_CNT = LIMIT[CW-1:0];

  logic [CW-1:0] count;

  // Wait-cycle counter: cleared when a bus cycle starts, advances while it runs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  // Expiry fires on the last permitted bus cycle so the abort takes effect at its end.
  always_comb begin
    if (TIMEOUT_CYC != 0) begin
      expired = (count == LIMIT_CNT);
    end else begin
      expired = 1'b0;
    end
  end

endmodule

// File: rtl/wshbn_slave_bridge.sv
// Turns each CPU-side rd/wr request into one Wishbone classic single cycle,
// returning read data with a one-cycle data_av strobe and flagging errors.
module wshbn_slave_bridge #(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hFFFF_FFFF
) (
  input logic             clk,
  input logic             rst,
  wshbn_slave_bridge_if.slave bus
);

  import wshbn_bridge_pkg::*;

  wshbn_state_t state;
  wshbn_state_t state_nxt;
  logic         accept;
  logic         capture;
  logic         fail;
  logic         expired;
  logic         cnt_en;

  wshbn_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (cnt_en),
    .expired (expired)
  );

  // Next-state decode; an error response beats a simultaneous ack.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    fail      = 1'b0;
    cnt_en    = (state == BUS);
    case (state)
      IDLE: begin
        if (bus.wshbn_rd ^ bus.wshbn_wr) begin
          accept    = 1'b1;
          state_nxt = BUS;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUS: begin
        if (bus.wb_err_i || expired) begin
          fail      = 1'b1;
          state_nxt = DONE;
        end else if (bus.wb_ack_i) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = BUS;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and the control strobes, all derived from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      bus.wb_cyc_o      <= 1'b0;
      bus.wb_stb_o      <= 1'b0;
      bus.wshbn_busy    <= 1'b0;
      bus.wshbn_data_av <= 1'b0;
      bus.bus_err_o     <= 1'b0;
    end else begin
      state             <= state_nxt;
      bus.wb_cyc_o      <= (state_nxt == BUS);
      bus.wb_stb_o      <= (state_nxt == BUS);
      bus.wshbn_busy    <= (state_nxt != IDLE);
      bus.wshbn_data_av <= (state_nxt == DONE);
      bus.bus_err_o     <= fail;
    end
  end

  // Request latches (held for the whole bus cycle) and the read-data return register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wb_we_o      <= 1'b0;
      bus.wb_adr_o     <= 32'h0000_0000;
      bus.wb_dat_o     <= 32'h0000_0000;
      bus.wb_sel_o     <= WB_SEL_WORD;
      bus.wshbn_data_o <= 32'h0000_0000;
    end else begin
      bus.wb_sel_o <= WB_SEL_WORD;
      if (accept) begin
        bus.wb_we_o  <= bus.wshbn_wr;
        bus.wb_adr_o <= word_to_byte_addr(bus.wshbn_addr_i);
        bus.wb_dat_o <= bus.wshbn_data_i;
      end
      // Writes never disturb the last read value.
      if (capture && !bus.wb_we_o) begin
        bus.wshbn_data_o <= bus.wb_dat_i;
      end else if (fail && !bus.wb_we_o) begin
        bus.wshbn_data_o <= ERR_DATA;
      end
    end
  end

endmodule
